// File: rtl/credit_tracker_mc_pkg.sv
// Shared types for the multi-channel command-credit tracker: channel FSM states,
// default widths and per-channel port bundles.
package credit_tracker_mc_pkg;

    localparam int DEF_NUM_CHANNELS = 4;
    localparam int DEF_CREDIT_WIDTH = 8;
    localparam int DEF_RESP_WIDTH   = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } credit_state_t;

    typedef logic [DEF_CREDIT_WIDTH-1:0]      credit_t;
    typedef logic signed [DEF_RESP_WIDTH-1:0] resp_credit_t;

    typedef struct packed {
        credit_t      room;
        logic         reinit;
        logic         valid_request;
        logic         valid_response;
        resp_credit_t response_credits;
    } CreditChannelIn;

    typedef struct packed {
        credit_t credits;
        logic    can_issue;
        logic    init_done;
        credit_t min_credits;
        logic    underflow_err;
        logic    overflow_err;
    } CreditChannelOut;

endpackage

// File: rtl/credit_tracker_mc_channel.sv
// One independent credit pool: IDLE/INIT/RUN FSM, netted signed update with
// saturation, low-watermark tracking and sticky range errors.
module credit_tracker_mc_channel
    import credit_tracker_mc_pkg::*;
#(
    parameter int CREDIT_WIDTH = DEF_CREDIT_WIDTH,
    parameter int RESP_WIDTH   = DEF_RESP_WIDTH,
    parameter int RESERVE      = 0
) (
    input  logic                    clock,
    input  logic                    rstn,
    input  logic [CREDIT_WIDTH-1:0] room,
    input  logic                    reinit,
    input  logic                    valid_request,
    input  logic                    valid_response,
    input  logic [RESP_WIDTH-1:0]   response_credits,
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic                    can_issue,
    output logic                    init_done,
    output logic [CREDIT_WIDTH-1:0] min_credits,
    output logic                    underflow_err,
    output logic                    overflow_err
);

    // Two guard bits keep credits + delta exact, so no result can wrap.
    localparam int SUM_W = CREDIT_WIDTH + 2;
    localparam logic [CREDIT_WIDTH-1:0] RESERVE_C = CREDIT_WIDTH'(RESERVE);

    credit_state_t state_reg, state_next;
    logic [CREDIT_WIDTH-1:0] credits_reg, credits_next;
    logic [CREDIT_WIDTH-1:0] room_max_reg, room_max_next;
    logic [CREDIT_WIDTH-1:0] min_reg, min_next;
    logic underflow_reg, underflow_next;
    logic overflow_reg, overflow_next;

    logic signed [SUM_W-1:0] delta;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] room_max_s;

    always_comb begin
        delta = '0;
        if (valid_response) begin
            delta = {{(SUM_W-RESP_WIDTH){response_credits[RESP_WIDTH-1]}}, response_credits};
        end
        if (valid_request) begin
            delta = delta - SUM_W'(1);
        end
        sum        = $signed({2'b00, credits_reg}) + delta;
        room_max_s = $signed({2'b00, room_max_reg});
    end

    always_comb begin
        state_next     = state_reg;
        credits_next   = credits_reg;
        room_max_next  = room_max_reg;
        min_next       = min_reg;
        underflow_next = underflow_reg;
        overflow_next  = overflow_reg;
        case (state_reg)
            IDLE: state_next = INIT;
            INIT: begin
                state_next     = RUN;
                credits_next   = room;
                room_max_next  = room;
                min_next       = room;
                underflow_next = 1'b0;
                overflow_next  = 1'b0;
            end
            RUN: begin
                if (reinit) begin
                    state_next = INIT;
                end
                if (sum < 0) begin
                    credits_next   = '0;
                    underflow_next = 1'b1;
                end else if (sum > room_max_s) begin
                    credits_next  = room_max_reg;
                    overflow_next = 1'b1;
                end else begin
                    credits_next = sum[CREDIT_WIDTH-1:0];
                end
                // Issuing against an empty pool is an error even if a return nets it out.
                if (valid_request && (credits_reg == '0)) begin
                    underflow_next = 1'b1;
                end
                if (credits_next < min_reg) begin
                    min_next = credits_next;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            credits_reg   <= '0;
            room_max_reg  <= '0;
            min_reg       <= '0;
            underflow_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            credits_reg   <= credits_next;
            room_max_reg  <= room_max_next;
            min_reg       <= min_next;
            underflow_reg <= underflow_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign credits       = credits_reg;
    assign init_done     = (state_reg == RUN);
    assign can_issue     = (state_reg == RUN) && (credits_reg > RESERVE_C);
    assign min_credits   = min_reg;
    assign underflow_err = underflow_reg;
    assign overflow_err  = overflow_reg;

endmodule

// File: rtl/credit_tracker_mc.sv
// Multi-channel PSL command-credit tracker: NUM_CHANNELS independent pools,
// the top level only slices the port arrays onto per-channel trackers.
module credit_tracker_mc
    import credit_tracker_mc_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int CREDIT_WIDTH = DEF_CREDIT_WIDTH,
    parameter int RESP_WIDTH   = DEF_RESP_WIDTH,
    parameter int RESERVE      = 0
) (
    input  logic                                       clock,
    input  logic                                       rstn,
    input  logic [NUM_CHANNELS-1:0][CREDIT_WIDTH-1:0]  room,
    input  logic [NUM_CHANNELS-1:0]                    reinit,
    input  logic [NUM_CHANNELS-1:0]                    valid_request,
    input  logic [NUM_CHANNELS-1:0]                    valid_response,
    input  logic [NUM_CHANNELS-1:0][RESP_WIDTH-1:0]    response_credits,
    output logic [NUM_CHANNELS-1:0][CREDIT_WIDTH-1:0]  credits,
    output logic [NUM_CHANNELS-1:0]                    can_issue,
    output logic [NUM_CHANNELS-1:0]                    init_done,
    output logic [NUM_CHANNELS-1:0][CREDIT_WIDTH-1:0]  min_credits,
    output logic [NUM_CHANNELS-1:0]                    underflow_err,
    output logic [NUM_CHANNELS-1:0]                    overflow_err
);

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_channel
            credit_tracker_mc_channel #(
                .CREDIT_WIDTH (CREDIT_WIDTH),
                .RESP_WIDTH   (RESP_WIDTH),
                .RESERVE      (RESERVE)
            ) u_channel (
                .clock            (clock),
                .rstn             (rstn),
                .room             (room[gi]),
                .reinit           (reinit[gi]),
                .valid_request    (valid_request[gi]),
                .valid_response   (valid_response[gi]),
                .response_credits (response_credits[gi]),
                .credits          (credits[gi]),
                .can_issue        (can_issue[gi]),
                .init_done        (init_done[gi]),
                .min_credits      (min_credits[gi]),
                .underflow_err    (underflow_err[gi]),
                .overflow_err     (overflow_err[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_credit_tracker_mc.sv
// Directed bench for credit_tracker_mc; a second instance with RESERVE=2 shares
// all inputs so the issue gate can be compared against the default instance.
module tb_credit_tracker_mc;

    logic             clock;
    logic             rstn;
    logic [3:0][7:0]  room;
    logic [3:0]       reinit;
    logic [3:0]       valid_request;
    logic [3:0]       valid_response;
    logic [3:0][8:0]  response_credits;

    logic [3:0][7:0]  credits;
    logic [3:0]       can_issue;
    logic [3:0]       init_done;
    logic [3:0][7:0]  min_credits;
    logic [3:0]       underflow_err;
    logic [3:0]       overflow_err;

    logic [3:0][7:0]  r_credits;
    logic [3:0]       r_can_issue;
    logic [3:0]       r_init_done;
    logic [3:0][7:0]  r_min_credits;
    logic [3:0]       r_underflow_err;
    logic [3:0]       r_overflow_err;

    int checks = 0;
    int errors = 0;

    credit_tracker_mc #(.NUM_CHANNELS(4), .CREDIT_WIDTH(8), .RESP_WIDTH(9), .RESERVE(0)) dut (
        .clock(clock), .rstn(rstn), .room(room), .reinit(reinit),
        .valid_request(valid_request), .valid_response(valid_response),
        .response_credits(response_credits), .credits(credits), .can_issue(can_issue),
        .init_done(init_done), .min_credits(min_credits),
        .underflow_err(underflow_err), .overflow_err(overflow_err)
    );

    credit_tracker_mc #(.NUM_CHANNELS(4), .CREDIT_WIDTH(8), .RESP_WIDTH(9), .RESERVE(2)) dut_r (
        .clock(clock), .rstn(rstn), .room(room), .reinit(reinit),
        .valid_request(valid_request), .valid_response(valid_response),
        .response_credits(response_credits), .credits(r_credits), .can_issue(r_can_issue),
        .init_done(r_init_done), .min_credits(r_min_credits),
        .underflow_err(r_underflow_err), .overflow_err(r_overflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        reinit           = '0;
        valid_request    = '0;
        valid_response   = '0;
        response_credits = '0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        clear_inputs();
        room = {8'd3, 8'd10, 8'd8, 8'd16};
        tick();
        tick();
        checks++;
        if (credits !== 32'h0 || min_credits !== 32'h0 || can_issue !== 4'h0 || init_done !== 4'h0
            || underflow_err !== 4'h0 || overflow_err !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: credits=%h min=%h can=%b done=%b uf=%b of=%b, want all 0",
                     credits, min_credits, can_issue, init_done, underflow_err, overflow_err);
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (init_done !== 4'h0) begin
            errors++;
            $display("FAIL init_cycle_done: got %b want 0000", init_done);
        end
        tick();
        checks++;
        if (init_done !== 4'hF) begin
            errors++;
            $display("FAIL init_done_run: got %b want 1111", init_done);
        end
        checks++;
        if (credits !== 32'h030A0810) begin
            errors++;
            $display("FAIL init_credits: got %h want 030a0810", credits);
        end
        checks++;
        if (can_issue !== 4'hF || min_credits !== 32'h030A0810) begin
            errors++;
            $display("FAIL init_can_min: can=%b min=%h want 1111 030a0810", can_issue, min_credits);
        end
        $display("test_reset: credits=%h init_done=%b", credits, init_done);
    endtask

    task automatic test_drain;
        for (int i = 0; i < 16; i++) begin
            valid_request[0] = 1'b1;
            tick();
        end
        valid_request[0] = 1'b0;
        checks++;
        if (credits[0] !== 8'd0 || can_issue[0] !== 1'b0) begin
            errors++;
            $display("FAIL drain_credits: credits=%0d can=%b want 0 0", credits[0], can_issue[0]);
        end
        checks++;
        if (min_credits[0] !== 8'd0 || underflow_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL drain_min_err: min=%0d uf=%b want 0 0", min_credits[0], underflow_err[0]);
        end
        valid_request[0] = 1'b1;
        tick();
        valid_request[0] = 1'b0;
        checks++;
        if (underflow_err[0] !== 1'b1 || credits[0] !== 8'd0) begin
            errors++;
            $display("FAIL issue_at_zero: uf=%b credits=%0d want 1 0", underflow_err[0], credits[0]);
        end
        $display("test_drain: credits0=%0d underflow0=%b", credits[0], underflow_err[0]);
    endtask

    task automatic test_netting;
        for (int i = 0; i < 3; i++) begin
            valid_request[1] = 1'b1;
            tick();
        end
        valid_request[1] = 1'b0;
        checks++;
        if (credits[1] !== 8'd5) begin
            errors++;
            $display("FAIL net_setup: got %0d want 5", credits[1]);
        end
        valid_request[1] = 1'b1;
        valid_response[1] = 1'b1;
        response_credits[1] = 9'd1;
        tick();
        valid_request[1] = 1'b0;
        checks++;
        if (credits[1] !== 8'd5) begin
            errors++;
            $display("FAIL net_req_resp: got %0d want 5", credits[1]);
        end
        response_credits[1] = 9'h1FD;
        tick();
        checks++;
        if (credits[1] !== 8'd2) begin
            errors++;
            $display("FAIL net_minus3: got %0d want 2", credits[1]);
        end
        response_credits[1] = 9'd4;
        tick();
        valid_response[1] = 1'b0;
        response_credits[1] = '0;
        checks++;
        if (credits[1] !== 8'd6 || min_credits[1] !== 8'd2 || overflow_err[1] !== 1'b0) begin
            errors++;
            $display("FAIL net_plus4: credits=%0d min=%0d of=%b want 6 2 0",
                     credits[1], min_credits[1], overflow_err[1]);
        end
        $display("test_netting: credits1=%0d min1=%0d", credits[1], min_credits[1]);
    endtask

    task automatic test_overflow;
        valid_request[2] = 1'b1;
        tick();
        valid_request[2] = 1'b0;
        valid_response[2] = 1'b1;
        response_credits[2] = 9'd5;
        tick();
        valid_response[2] = 1'b0;
        response_credits[2] = '0;
        checks++;
        if (credits[2] !== 8'd10 || overflow_err[2] !== 1'b1) begin
            errors++;
            $display("FAIL overflow_clamp: credits=%0d of=%b want 10 1", credits[2], overflow_err[2]);
        end
        valid_request[2] = 1'b1;
        tick();
        valid_request[2] = 1'b0;
        checks++;
        if (credits[2] !== 8'd9 || overflow_err[2] !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: credits=%0d of=%b want 9 1", credits[2], overflow_err[2]);
        end
        reinit[2] = 1'b1;
        tick();
        reinit[2] = 1'b0;
        checks++;
        if (init_done[2] !== 1'b0 || can_issue[2] !== 1'b0) begin
            errors++;
            $display("FAIL reinit_state: done=%b can=%b want 0 0", init_done[2], can_issue[2]);
        end
        valid_request[2] = 1'b1;
        tick();
        valid_request[2] = 1'b0;
        checks++;
        if (credits[2] !== 8'd10 || overflow_err[2] !== 1'b0 || init_done[2] !== 1'b1
            || min_credits[2] !== 8'd10) begin
            errors++;
            $display("FAIL reinit_reload: credits=%0d of=%b done=%b min=%0d want 10 0 1 10",
                     credits[2], overflow_err[2], init_done[2], min_credits[2]);
        end
        $display("test_overflow: credits2=%0d overflow2=%b", credits[2], overflow_err[2]);
    endtask

    task automatic test_reserve;
        checks++;
        if (r_can_issue[3] !== 1'b1 || can_issue[3] !== 1'b1) begin
            errors++;
            $display("FAIL reserve_at3: r_can=%b can=%b want 1 1", r_can_issue[3], can_issue[3]);
        end
        valid_request[3] = 1'b1;
        tick();
        valid_request[3] = 1'b0;
        checks++;
        if (r_credits[3] !== 8'd2 || r_can_issue[3] !== 1'b0 || can_issue[3] !== 1'b1) begin
            errors++;
            $display("FAIL reserve_at2: r_credits=%0d r_can=%b can=%b want 2 0 1",
                     r_credits[3], r_can_issue[3], can_issue[3]);
        end
        $display("test_reserve: r_credits3=%0d r_can_issue3=%b", r_credits[3], r_can_issue[3]);
    endtask

    task automatic test_multichannel;
        // Entry state: ch0=0 (underflow set), ch1=6, ch2=10, ch3=2.
        valid_response      = 4'b1101;
        response_credits[0] = 9'd7;
        response_credits[2] = 9'h1FC;
        response_credits[3] = 9'd1;
        valid_request       = 4'b0110;
        tick();
        checks++;
        if (credits !== 32'h03050507) begin
            errors++;
            $display("FAIL multi_credits: got %h want 03050507", credits);
        end
        checks++;
        if (min_credits !== 32'h02050200 || underflow_err !== 4'b0001 || overflow_err !== 4'b0000) begin
            errors++;
            $display("FAIL multi_min_err: min=%h uf=%b of=%b want 02050200 0001 0000",
                     min_credits, underflow_err, overflow_err);
        end
        tick();
        checks++;
        if (credits !== 32'h0300040E || overflow_err !== 4'b1000) begin
            errors++;
            $display("FAIL burst_step: credits=%h of=%b want 0300040e 1000", credits, overflow_err);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (credits !== 32'h0 || min_credits !== 32'h0 || can_issue !== 4'h0 || init_done !== 4'h0
            || underflow_err !== 4'h0 || overflow_err !== 4'h0) begin
            errors++;
            $display("FAIL midburst_reset: credits=%h min=%h can=%b done=%b uf=%b of=%b want all 0",
                     credits, min_credits, can_issue, init_done, underflow_err, overflow_err);
        end
        clear_inputs();
        tick();
        rstn = 1'b1;
        tick();
        checks++;
        if (init_done !== 4'h0 || credits !== 32'h0) begin
            errors++;
            $display("FAIL reinit_after_rst: done=%b credits=%h want 0000 0", init_done, credits);
        end
        tick();
        checks++;
        if (credits !== 32'h030A0810 || init_done !== 4'hF || underflow_err !== 4'h0) begin
            errors++;
            $display("FAIL rerun_after_rst: credits=%h done=%b uf=%b want 030a0810 1111 0000",
                     credits, init_done, underflow_err);
        end
        $display("test_multichannel: credits=%h init_done=%b", credits, init_done);
    endtask

    initial begin
        test_reset();
        test_drain();
        test_netting();
        test_overflow();
        test_reserve();
        test_multichannel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
